// File: rtl/fcl_dxl_pkg.sv
// -----------------------------------------------------------------------------
// fcl_dxl_pkg
// Shared definitions for the Dynamixel-style packet receiver:
//   - dxl_state_e    : parser state enumeration
//   - ERR_*          : pkt_err_code values
//   - HDR_BYTE       : frame header byte (two of them start a frame)
//   - BCAST_ID       : broadcast servo ID
//   - INSTR_*        : instruction opcodes
//   - csum_add       : 8-bit wrap-around checksum accumulation
// -----------------------------------------------------------------------------
package fcl_dxl_pkg;

    typedef enum logic [2:0] {
        ST_HDR1  = 3'd0,
        ST_HDR2  = 3'd1,
        ST_ID    = 3'd2,
        ST_LEN   = 3'd3,
        ST_INSTR = 3'd4,
        ST_PARAM = 3'd5,
        ST_CSUM  = 3'd6
    } dxl_state_e;

    localparam logic [1:0] ERR_CSUM    = 2'd1;
    localparam logic [1:0] ERR_LEN     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] HDR_BYTE = 8'hFF;
    localparam logic [7:0] BCAST_ID = 8'hFE;

    localparam logic [7:0] INSTR_PING  = 8'h01;
    localparam logic [7:0] INSTR_READ  = 8'h02;
    localparam logic [7:0] INSTR_WRITE = 8'h03;

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/fcl_dxl_param_buf.sv
// -----------------------------------------------------------------------------
// fcl_dxl_param_buf
// Parameter byte store for the packet receiver. Write-indexed register array
// with a combinational read port.
// Ports:
//   sys_clk, _reset      clock / asynchronous active-low reset (clears array)
//   wr_en, wr_addr,
//   wr_data              write one parameter byte at wr_addr
//   rd_addr              read address
//   rd_count             number of valid entries; reads at or above it give 0
//   rd_data              combinational read data
// -----------------------------------------------------------------------------
module fcl_dxl_param_buf
    import fcl_dxl_pkg::*;
#(
    parameter int MAX_PARAMS = 16
) (
    input  logic       sys_clk,
    input  logic       _reset,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [4:0] rd_addr,
    input  logic [4:0] rd_count,
    output logic [7:0] rd_data
);

    localparam logic [5:0] DEPTH = 6'(MAX_PARAMS);

    // Entries at or above MAX_PARAMS are never written and stay at their
    // reset value, so they reduce to constants.
    logic [7:0] mem_q [32];
    logic [7:0] mem_d [32];

    always_comb begin
        mem_d = mem_q;
        if (wr_en && ({1'b0, wr_addr} < DEPTH)) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge sys_clk or negedge _reset) begin
        if (!_reset) begin
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        rd_data = 8'h00;
        if (rd_addr < rd_count) begin
            rd_data = mem_q[rd_addr];
        end
    end

endmodule

// File: rtl/fcl_dxl_packet_rx.sv
// -----------------------------------------------------------------------------
// fcl_dxl_packet_rx
// Byte-stream parser for frames  FF FF ID LEN INSTR P0..Pn-1 CSUM  (n = LEN-2,
// CSUM = ~(ID+LEN+INSTR+sum(P)) mod 256). Reports good packets, checksum /
// length / inter-byte-timeout errors, and exposes the last good packet's
// header fields and parameter bytes.
//
// Optional build macro: DXL_ID_FILTER_EN -- when defined, frames whose ID is
// neither MY_ID nor broadcast (FE) are parsed but dropped without any strobe
// (checksum and length errors on them are silent too).
//
// Ports:
//   sys_clk, _reset          clock / asynchronous active-low reset
//   rx_data, rx_data_valid   received byte and its one-cycle strobe
//   pkt_valid                one-cycle strobe: good packet accepted
//   pkt_error                one-cycle strobe: packet aborted
//   pkt_err_code             1=checksum 2=length 3=timeout, held until next error
//   pkt_id, pkt_instr,
//   pkt_param_count          fields of the last good packet
//   param_rd_addr/_data      combinational parameter buffer read
//   rx_busy                  high whenever a frame is in progress
// -----------------------------------------------------------------------------
module fcl_dxl_packet_rx
    import fcl_dxl_pkg::*;
#(
    parameter int         MAX_PARAMS     = 16,
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter logic [7:0] MY_ID          = 8'h01
) (
    input  logic       sys_clk,
    input  logic       _reset,
    input  logic [7:0] rx_data,
    input  logic       rx_data_valid,
    output logic       pkt_valid,
    output logic       pkt_error,
    output logic [1:0] pkt_err_code,
    output logic [7:0] pkt_id,
    output logic [7:0] pkt_instr,
    output logic [4:0] pkt_param_count,
    input  logic [4:0] param_rd_addr,
    output logic [7:0] param_rd_data,
    output logic       rx_busy
);

    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       LEN_MAX  = 8'(MAX_PARAMS + 2);

    dxl_state_e       state_q, state_d;
    logic [7:0]       id_q, id_d;
    logic [7:0]       instr_q, instr_d;
    logic [4:0]       n_q, n_d;
    logic [4:0]       idx_q, idx_d;
    logic [7:0]       csum_q, csum_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             drop_q, drop_d;
    logic             pkt_valid_q, pkt_valid_d;
    logic             pkt_error_q, pkt_error_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [7:0]       pkt_id_q, pkt_id_d;
    logic [7:0]       pkt_instr_q, pkt_instr_d;
    logic [4:0]       pkt_cnt_q, pkt_cnt_d;

    logic             timeout_hit;
    logic             buf_wr_en;
    logic             id_dropped;

`ifdef DXL_ID_FILTER_EN
    assign id_dropped = (rx_data != MY_ID) && (rx_data != BCAST_ID);
`else
    assign id_dropped = 1'b0;
    logic unused_my_id;
    assign unused_my_id = ^MY_ID;
`endif

    // Expiry happens on the idle cycle that would bring the count to
    // TIMEOUT_CYCLES; a byte on that same cycle wins and clears the count.
    assign timeout_hit = !rx_data_valid && (state_q != ST_HDR1) && (tmo_q == TMO_LAST);

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        instr_d     = instr_q;
        n_d         = n_q;
        idx_d       = idx_q;
        csum_d      = csum_q;
        drop_d      = drop_q;
        pkt_valid_d = 1'b0;
        pkt_error_d = 1'b0;
        err_code_d  = err_code_q;
        pkt_id_d    = pkt_id_q;
        pkt_instr_d = pkt_instr_q;
        pkt_cnt_d   = pkt_cnt_q;
        buf_wr_en   = 1'b0;

        if (rx_data_valid || (state_q == ST_HDR1) || timeout_hit) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        if (timeout_hit) begin
            pkt_error_d = 1'b1;
            err_code_d  = ERR_TIMEOUT;
            state_d     = ST_HDR1;
        end else if (rx_data_valid) begin
            unique case (state_q)
                ST_HDR1: begin
                    if (rx_data == HDR_BYTE) state_d = ST_HDR2;
                end
                ST_HDR2: begin
                    if (rx_data == HDR_BYTE) begin
                        state_d = ST_ID;
                        csum_d  = 8'h00;
                    end else begin
                        state_d = ST_HDR1;
                    end
                end
                ST_ID: begin
                    // Extra FF bytes before the ID are a redundant header.
                    if (rx_data != HDR_BYTE) begin
                        id_d    = rx_data;
                        drop_d  = id_dropped;
                        csum_d  = csum_add(csum_q, rx_data);
                        state_d = ST_LEN;
                    end
                end
                ST_LEN: begin
                    if ((rx_data < 8'd2) || (rx_data > LEN_MAX)) begin
                        pkt_error_d = !drop_q;
                        if (!drop_q) err_code_d = ERR_LEN;
                        state_d = ST_HDR1;
                    end else begin
                        n_d     = 5'(rx_data - 8'd2);
                        csum_d  = csum_add(csum_q, rx_data);
                        state_d = ST_INSTR;
                    end
                end
                ST_INSTR: begin
                    instr_d = rx_data;
                    csum_d  = csum_add(csum_q, rx_data);
                    idx_d   = 5'd0;
                    state_d = (n_q != 5'd0) ? ST_PARAM : ST_CSUM;
                end
                ST_PARAM: begin
                    buf_wr_en = 1'b1;
                    csum_d    = csum_add(csum_q, rx_data);
                    idx_d     = idx_q + 5'd1;
                    if (idx_q == (n_q - 5'd1)) state_d = ST_CSUM;
                end
                ST_CSUM: begin
                    if (rx_data == ~csum_q) begin
                        if (!drop_q) begin
                            pkt_valid_d = 1'b1;
                            pkt_id_d    = id_q;
                            pkt_instr_d = instr_q;
                            pkt_cnt_d   = n_q;
                        end
                    end else if (!drop_q) begin
                        pkt_error_d = 1'b1;
                        err_code_d  = ERR_CSUM;
                    end
                    state_d = ST_HDR1;
                end
                default: state_d = ST_HDR1;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge _reset) begin
        if (!_reset) begin
            state_q     <= ST_HDR1;
            id_q        <= 8'h00;
            instr_q     <= 8'h00;
            n_q         <= 5'd0;
            idx_q       <= 5'd0;
            csum_q      <= 8'h00;
            tmo_q       <= '0;
            drop_q      <= 1'b0;
            pkt_valid_q <= 1'b0;
            pkt_error_q <= 1'b0;
            err_code_q  <= 2'd0;
            pkt_id_q    <= 8'h00;
            pkt_instr_q <= 8'h00;
            pkt_cnt_q   <= 5'd0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            instr_q     <= instr_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            csum_q      <= csum_d;
            tmo_q       <= tmo_d;
            drop_q      <= drop_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_error_q <= pkt_error_d;
            err_code_q  <= err_code_d;
            pkt_id_q    <= pkt_id_d;
            pkt_instr_q <= pkt_instr_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

    fcl_dxl_param_buf #(
        .MAX_PARAMS (MAX_PARAMS)
    ) u_param_buf (
        .sys_clk  (sys_clk),
        ._reset   (_reset),
        .wr_en    (buf_wr_en),
        .wr_addr  (idx_q),
        .wr_data  (rx_data),
        .rd_addr  (param_rd_addr),
        .rd_count (pkt_cnt_q),
        .rd_data  (param_rd_data)
    );

    assign pkt_valid       = pkt_valid_q;
    assign pkt_error       = pkt_error_q;
    assign pkt_err_code    = err_code_q;
    assign pkt_id          = pkt_id_q;
    assign pkt_instr       = pkt_instr_q;
    assign pkt_param_count = pkt_cnt_q;
    assign rx_busy         = (state_q != ST_HDR1);

endmodule

// File: tb/tb_fcl_dxl_packet_rx.sv
// -----------------------------------------------------------------------------
// tb_fcl_dxl_packet_rx
// Directed and randomized frames against a frame-level reference model of the
// receiver (expected strobes, latched fields and parameter bytes).
// -----------------------------------------------------------------------------
module tb_fcl_dxl_packet_rx;
    import fcl_dxl_pkg::*;

    localparam int         MAXP = 16;
    localparam int         TMO  = 20;
    localparam logic [7:0] MYID = 8'h01;

    localparam int K_GOOD = 0;
    localparam int K_CSUM = 1;
    localparam int K_LEN  = 2;

    logic       sys_clk = 1'b0;
    logic       _reset;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       pkt_valid, pkt_error, rx_busy;
    logic [1:0] pkt_err_code;
    logic [7:0] pkt_id, pkt_instr, param_rd_data;
    logic [4:0] pkt_param_count, param_rd_addr;

    fcl_dxl_packet_rx #(
        .MAX_PARAMS     (MAXP),
        .TIMEOUT_CYCLES (TMO),
        .MY_ID          (MYID)
    ) dut (
        .sys_clk         (sys_clk),
        ._reset          (_reset),
        .rx_data         (rx_data),
        .rx_data_valid   (rx_data_valid),
        .pkt_valid       (pkt_valid),
        .pkt_error       (pkt_error),
        .pkt_err_code    (pkt_err_code),
        .pkt_id          (pkt_id),
        .pkt_instr       (pkt_instr),
        .pkt_param_count (pkt_param_count),
        .param_rd_addr   (param_rd_addr),
        .param_rd_data   (param_rd_data),
        .rx_busy         (rx_busy)
    );

    always #5 sys_clk = ~sys_clk;

    int n_assert = 0;
    int n_fail   = 0;
    int nv = 0;
    int ne = 0;

    // Reference model state: last good packet and held error code.
    logic [7:0] exp_id, exp_instr;
    logic [1:0] exp_code;
    int         exp_cnt;
    logic [7:0] exp_par [32];
    logic [7:0] fp [32];

    always @(negedge sys_clk) begin
        if (pkt_valid === 1'b1) nv <= nv + 1;
        if (pkt_error === 1'b1) ne <= ne + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data       = b;
        rx_data_valid = 1'b1;
        @(negedge sys_clk);
        rx_data_valid = 1'b0;
    endtask

    task automatic gap(input int maxgap);
        if (maxgap > 0) idle(int'($urandom_range(0, maxgap)));
    endtask

    // Checksum straight from the frame definition.
    function automatic logic [7:0] model_csum(input logic [7:0] id, input logic [7:0] len,
                                              input logic [7:0] instr, input int n);
        int s;
        s = int'(id) + int'(len) + int'(instr);
        for (int i = 0; i < n; i++) s += int'(fp[i]);
        return ~(8'(s));
    endfunction

    task automatic send_frame(input logic [7:0] id, input logic [7:0] len, input logic [7:0] instr,
                              input logic [7:0] cs, input int extra_ff, input int maxgap,
                              input bit stop_after_len);
        int n;
        send_byte(8'hFF); gap(maxgap); send_byte(8'hFF);
        for (int i = 0; i < extra_ff; i++) begin gap(maxgap); send_byte(8'hFF); end
        gap(maxgap); send_byte(id);
        gap(maxgap); send_byte(len);
        if (!stop_after_len) begin
            n = int'(len) - 2;
            gap(maxgap); send_byte(instr);
            for (int i = 0; i < n; i++) begin gap(maxgap); send_byte(fp[i]); end
            gap(maxgap); send_byte(cs);
        end
    endtask

    // Called at the negedge right after the frame's last byte was sampled.
    task automatic check_outcome(input string tag, input int kind, input logic [7:0] id,
                                 input logic [7:0] instr, input int n, input int nv0, input int ne0);
        bit drop;
        int ev, ee;
        drop = 1'b0;
`ifdef DXL_ID_FILTER_EN
        drop = (id != MYID) && (id != 8'hFE);
`endif
        ev = (!drop && kind == K_GOOD) ? 1 : 0;
        ee = (!drop && kind != K_GOOD) ? 1 : 0;
        chk({tag, ".valid"}, 32'(pkt_valid), 32'(ev));
        chk({tag, ".error"}, 32'(pkt_error), 32'(ee));
        if (ev == 1) begin
            exp_id    = id;
            exp_instr = instr;
            exp_cnt   = n;
            for (int i = 0; i < n; i++) exp_par[i] = fp[i];
        end
        if (ee == 1) exp_code = (kind == K_LEN) ? 2'd2 : 2'd1;
        idle(1);
        chk({tag, ".valid_pulse"}, 32'(pkt_valid), 32'd0);
        chk({tag, ".error_pulse"}, 32'(pkt_error), 32'd0);
        chk({tag, ".code"}, 32'(pkt_err_code), 32'(exp_code));
        chk({tag, ".id"}, 32'(pkt_id), 32'(exp_id));
        chk({tag, ".instr"}, 32'(pkt_instr), 32'(exp_instr));
        chk({tag, ".count"}, 32'(pkt_param_count), 32'(exp_cnt));
        chk({tag, ".busy"}, 32'(rx_busy), 32'd0);
        idle(1);
        chk({tag, ".nvalid"}, 32'(nv - nv0), 32'(ev));
        chk({tag, ".nerror"}, 32'(ne - ne0), 32'(ee));
        if (ev == 1) begin
            for (int i = 0; i < exp_cnt; i++) begin
                param_rd_addr = 5'(i);
                #1 chk({tag, ".param"}, 32'(param_rd_data), 32'(exp_par[i]));
            end
            param_rd_addr = 5'(exp_cnt);
            #1 chk({tag, ".param_oob"}, 32'(param_rd_data), 32'd0);
            param_rd_addr = 5'd31;
            #1 chk({tag, ".param_31"}, 32'(param_rd_data), 32'd0);
            @(negedge sys_clk);
        end
    endtask

    initial begin
        int         nv0, ne0, kind, n;
        logic [7:0] id, len, instr, cs;

        _reset        = 1'b0;
        rx_data       = 8'h00;
        rx_data_valid = 1'b0;
        param_rd_addr = 5'd0;
        exp_id = 8'h00; exp_instr = 8'h00; exp_code = 2'd0; exp_cnt = 0;
        for (int i = 0; i < 32; i++) begin exp_par[i] = 8'h00; fp[i] = 8'h00; end

        // Reset state
        idle(3);
        chk("rst.valid", 32'(pkt_valid), 32'd0);
        chk("rst.error", 32'(pkt_error), 32'd0);
        chk("rst.code", 32'(pkt_err_code), 32'd0);
        chk("rst.id", 32'(pkt_id), 32'd0);
        chk("rst.instr", 32'(pkt_instr), 32'd0);
        chk("rst.count", 32'(pkt_param_count), 32'd0);
        chk("rst.busy", 32'(rx_busy), 32'd0);
        chk("rst.param", 32'(param_rd_data), 32'd0);
        _reset = 1'b1;
        idle(2);

        // Known good frame: FF FF 01 04 03 1E 00 D9
        fp[0] = 8'h1E; fp[1] = 8'h00;
        nv0 = nv; ne0 = ne;
        send_frame(8'h01, 8'h04, INSTR_WRITE, 8'hD9, 0, 0, 1'b0);
        check_outcome("good039", K_GOOD, 8'h01, INSTR_WRITE, 2, nv0, ne0);

        // Same frame, bad checksum D8
        nv0 = nv; ne0 = ne;
        send_frame(8'h01, 8'h04, INSTR_WRITE, 8'hD8, 0, 0, 1'b0);
        check_outcome("csum040", K_CSUM, 8'h01, INSTR_WRITE, 2, nv0, ne0);

        // LEN 0x40 exceeds MAX_PARAMS: error right after the LEN byte
        nv0 = nv; ne0 = ne;
        send_frame(8'h01, 8'h40, 8'h00, 8'h00, 0, 0, 1'b1);
        check_outcome("len041", K_LEN, 8'h01, 8'h00, 0, nv0, ne0);
        nv0 = nv; ne0 = ne;
        send_frame(8'h01, 8'h04, INSTR_WRITE, 8'hD9, 0, 0, 1'b0);
        check_outcome("after_len", K_GOOD, 8'h01, INSTR_WRITE, 2, nv0, ne0);

        // Timeout: a full TIMEOUT_CYCLES gap aborts the frame
        send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h01);
        idle(TMO - 1);
        chk("tmo.before", 32'(pkt_error), 32'd0);
        chk("tmo.busy_before", 32'(rx_busy), 32'd1);
        idle(1);
        chk("tmo.error", 32'(pkt_error), 32'd1);
        chk("tmo.code", 32'(pkt_err_code), 32'd3);
        chk("tmo.busy_after", 32'(rx_busy), 32'd0);
        exp_code = 2'd3;
        idle(2);

        // A gap of TIMEOUT_CYCLES-1 is still in time
        nv0 = nv; ne0 = ne;
        send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h01);
        idle(TMO - 1);
        send_byte(8'h04); send_byte(INSTR_WRITE); send_byte(8'h1E); send_byte(8'h00);
        send_byte(8'hD9);
        check_outcome("tmo_edge", K_GOOD, 8'h01, INSTR_WRITE, 2, nv0, ne0);

        // Redundant header, ID 05 PING
        nv0 = nv; ne0 = ne;
        send_frame(8'h05, 8'h02, INSTR_PING, 8'hF7, 1, 0, 1'b0);
        check_outcome("ping043", K_GOOD, 8'h05, INSTR_PING, 0, nv0, ne0);

        // Broadcast ID is accepted in every build
        fp[0] = 8'hA5; fp[1] = 8'hFF; fp[2] = 8'h3C;
        cs = model_csum(8'hFE, 8'h05, INSTR_READ, 3);
        nv0 = nv; ne0 = ne;
        send_frame(8'hFE, 8'h05, INSTR_READ, cs, 0, 2, 1'b0);
        check_outcome("bcast", K_GOOD, 8'hFE, INSTR_READ, 3, nv0, ne0);

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            kind = int'($urandom_range(0, 9));
            kind = (kind == 0) ? K_LEN : (kind <= 2) ? K_CSUM : K_GOOD;
            case ($urandom_range(0, 5))
                0, 1:    id = MYID;
                2:       id = 8'hFE;
                default: id = 8'($urandom_range(0, 254));
            endcase
            case ($urandom_range(0, 3))
                0:       instr = INSTR_PING;
                1:       instr = INSTR_READ;
                2:       instr = INSTR_WRITE;
                default: instr = 8'($urandom_range(0, 255));
            endcase
            n = int'($urandom_range(0, MAXP));
            for (int i = 0; i < n; i++) fp[i] = 8'($urandom_range(0, 255));
            len = 8'(n + 2);
            if (kind == K_LEN) begin
                case ($urandom_range(0, 2))
                    0:       len = 8'h00;
                    1:       len = 8'h01;
                    default: len = 8'($urandom_range(MAXP + 3, 254));
                endcase
            end
            cs = model_csum(id, len, instr, n);
            if (kind == K_CSUM) cs = cs ^ 8'($urandom_range(1, 255));
            if ($urandom_range(0, 2) == 0) send_byte(8'($urandom_range(0, 254)));
            nv0 = nv; ne0 = ne;
            send_frame(id, len, instr, cs, int'($urandom_range(0, 1)), 3, kind == K_LEN);
            check_outcome("rand", kind, id, instr, (kind == K_LEN) ? 0 : n, nv0, ne0);
        end

        // Reset mid-PARAM: partial frame discarded, no strobe afterwards
        nv0 = nv; ne0 = ne;
        send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h01); send_byte(8'h05);
        send_byte(INSTR_WRITE); send_byte(8'hAA);
        #2 _reset = 1'b0;
        param_rd_addr = 5'd0;
        #1;
        chk("rstmid.busy", 32'(rx_busy), 32'd0);
        chk("rstmid.id", 32'(pkt_id), 32'd0);
        chk("rstmid.instr", 32'(pkt_instr), 32'd0);
        chk("rstmid.count", 32'(pkt_param_count), 32'd0);
        chk("rstmid.code", 32'(pkt_err_code), 32'd0);
        chk("rstmid.param", 32'(param_rd_data), 32'd0);
        @(negedge sys_clk);
        _reset = 1'b1;
        exp_id = 8'h00; exp_instr = 8'h00; exp_code = 2'd0; exp_cnt = 0;
        send_byte(8'hBB); send_byte(8'h12);
        idle(4);
        chk("rstmid.nvalid", 32'(nv - nv0), 32'd0);
        chk("rstmid.nerror", 32'(ne - ne0), 32'd0);
        chk("rstmid.busy_after", 32'(rx_busy), 32'd0);
        chk("rstmid.id_after", 32'(pkt_id), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fcl_dxl_packet_rx.md
FCL_DXL_PACKET_RX -- requirements
Module: fcl_dxl_packet_rx

Interface
REQ-001 SHALL have parameter MAX_PARAMS, default 16, maximum parameter bytes stored per packet (1..31).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000, maximum idle sys_clk cycles allowed between bytes inside a packet.
REQ-003 SHALL have parameter MY_ID, default 8'h01, servo ID that this node accepts.
REQ-004 Ports: sys_clk  in  1  system clock.
REQ-005 Ports: _reset  in  1  reset; asynchronous, active-low.
REQ-006 Ports: rx_data  in  8  received byte from the UART receiver.
REQ-007 Ports: rx_data_valid  in  1  one-cycle strobe, one per byte.
REQ-008 Ports: pkt_valid  out  1  one-cycle strobe, good packet accepted.
REQ-009 Ports: pkt_error  out  1  one-cycle strobe, packet aborted.
REQ-010 Ports: pkt_err_code  out  2  1=checksum, 2=length, 3=timeout; held until next pkt_error.
REQ-011 Ports: pkt_id, pkt_instr  out  8 each  ID and instruction of the last good packet.
REQ-012 Ports: pkt_param_count  out  5  parameter count of the last good packet.
REQ-013 Ports: param_rd_addr  in  5  and param_rd_data  out  8  combinational read of the parameter buffer.
REQ-014 Ports: rx_busy  out  1  high in any state other than HDR1.

Function
REQ-015 Frame format SHALL be: FF FF ID LEN INSTR P0..Pn-1 CSUM, where n = LEN-2 and CSUM = ~(ID+LEN+INSTR+ΣP) mod 256.
REQ-016 States SHALL be HDR1, HDR2, ID, LEN, INSTR, PARAM, CSUM, each advancing only on a cycle with rx_data_valid=1.
REQ-017 HDR1: byte FF -> HDR2; any other byte is ignored.
REQ-018 HDR2: byte FF -> ID; any other byte -> HDR1, with no error.
REQ-019 ID: byte FF -> stays in ID (redundant header); any other byte is latched and the state goes to LEN.
REQ-020 LEN: LEN<2 or LEN-2>MAX_PARAMS -> pkt_error with code 2 and return to HDR1; otherwise -> INSTR.
REQ-021 INSTR: after this byte, goes to PARAM if n>0, else to CSUM.
REQ-022 PARAM: each byte SHALL be written to buffer[index] and index incremented; after byte n-1, goes to CSUM.
REQ-023 The running checksum SHALL be an 8-bit accumulator, wrap-around, cleared on entry to ID.
REQ-024 CSUM: on match, pkt_valid SHALL pulse on the cycle after the CSUM strobe, with pkt_id, pkt_instr, pkt_param_count updated on that same cycle.
REQ-025 CSUM: on mismatch, pkt_error with code 1; pkt_id, pkt_instr, pkt_param_count SHALL be unchanged.
REQ-026 After CSUM, SHALL always return to HDR1.
REQ-027 Timeout counter SHALL reset on every rx_data_valid; in any state other than HDR1, reaching TIMEOUT_CYCLES -> pkt_error with code 3 and return to HDR1.
REQ-028 A byte arriving on the same cycle as timeout expiry SHALL be treated as arriving in time; the counter is cleared.
REQ-029 The parameter buffer SHALL be valid from pkt_valid until the first PARAM byte of the next packet.
REQ-030 param_rd_addr >= pkt_param_count SHALL return 8'h00.
REQ-031 pkt_valid and pkt_error SHALL never assert in the same cycle.

Reset
REQ-032 On _reset low: state HDR1; pkt_valid, pkt_error, pkt_err_code, pkt_id, pkt_instr, pkt_param_count, rx_busy all 0; parameter buffer cleared; timeout counter 0.
REQ-033 Reset asserted mid-packet SHALL discard the partial packet and produce no strobe after release.

Configuration
REQ-034 With DXL_ID_FILTER_EN defined, a packet whose ID is neither MY_ID nor 8'hFE (broadcast) SHALL be parsed fully and then dropped silently: no pkt_valid, no pkt_error, outputs unchanged.
REQ-035 With DXL_ID_FILTER_EN defined, checksum and length errors on a dropped ID SHALL also be silent.
REQ-036 Without DXL_ID_FILTER_EN, every ID SHALL be accepted and MY_ID is unused.

Structure
REQ-037 Package fcl_dxl_pkg SHALL hold the state enumeration, the error-code constants (ERR_CSUM=1, ERR_LEN=2, ERR_TIMEOUT=3), the header byte 8'hFF, the broadcast ID 8'hFE, and the instruction opcodes (PING=01, READ=02, WRITE=03).
REQ-038 A sub-module fcl_dxl_param_buf SHALL hold the write-indexed register array with combinational read port; all other logic is flat.

Verification
REQ-039 Bytes FF FF 01 04 03 1E 00 D9 -> one pkt_valid, pkt_id=01, pkt_instr=03, count=2, params 1E,00.
REQ-040 Same frame with CSUM=D8 -> pkt_error, code 1, no pkt_valid, previous pkt_id retained.
REQ-041 FF FF 01 40 ... with MAX_PARAMS=16 -> pkt_error, code 2, immediately after the LEN byte; next good frame accepted.
REQ-042 FF FF 01 then a gap of TIMEOUT_CYCLES -> pkt_error, code 3, rx_busy falls; a gap of TIMEOUT_CYCLES-1 -> no error.
REQ-043 FF FF FF 05 02 01 F7 (ID 05, LEN 02, PING, CSUM F7) -> pkt_valid, pkt_id=05, count=0.
REQ-044 With DXL_ID_FILTER_EN and MY_ID=01: ID 05 frame -> no strobe; ID FE frame -> pkt_valid; _reset pulsed mid-PARAM -> no strobe, outputs zero.
